// File: rtl/mips_mem_arbiter.sv
// Two-requester memory arbiter for a MIPS core and a loader/debug port.
// Optional build macro: ARB_ROUND_ROBIN_EN (round-robin ties; otherwise fixed core priority).

module mips_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            req_done,
    output logic [DATA_W-1:0]     req_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    // state  | meaning
    // IDLE   | waiting for a request; arbitration and request capture
    // ACCESS | memory strobed for MEM_LAT cycles, counter runs down to zero
    // DONE   | one-cycle completion pulse to the winner
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int CNT_W = 3;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               load;
    logic               capture;
    logic               grant_idx;
    logic               winner;
    logic               lat_we;
    logic [ADDR_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_wdata;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_served;

    // Tie goes to whoever was not served last; a lone request always wins.
    always_comb begin
        grant_idx = ~req_valid[0];
        if (&req_valid) begin
            grant_idx = ~last_served;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_served <= 1'b1;
        end else if (state == DONE) begin
            last_served <= winner;
        end
    end
`else
    always_comb begin
        grant_idx = ~req_valid[0];
    end
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    load      = 1'b1;
                    cnt_nxt   = CNT_W'(MEM_LAT - 1);
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    capture   = ~lat_we;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            winner    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (load) begin
            winner    <= grant_idx;
            lat_we    <= req_we[grant_idx];
            lat_addr  <= grant_idx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
            lat_wdata <= grant_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_rdata <= '0;
        end else if (capture) begin
            req_rdata <= mem_rdata;
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    always_comb begin
        mem_en    = (state == ACCESS);
        mem_we    = (state == ACCESS) & lat_we;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        req_done  = 2'b00;
        if (state == DONE) begin
            req_done = winner ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench for mips_mem_arbiter: three instances with MEM_LAT = 1, 2, 3.
// Expected completions are queued at issue time; a forked monitor pops and compares.

module tb_mips_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n [3];
    logic [1:0]  rv    [3];
    logic [1:0]  rwe   [3];
    logic [63:0] ra    [3];
    logic [63:0] rwd   [3];
    logic [1:0]  dn    [3];
    logic [31:0] rd    [3];
    logic        men   [3];
    logic        mwe   [3];
    logic [31:0] maddr [3];
    logic [31:0] mwd   [3];
    logic [31:0] mrd   [3];

    always #5 clk = ~clk;

    mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_l1 (
        .clk(clk), .reset(rst_n[0]), .req_valid(rv[0]), .req_we(rwe[0]),
        .req_addr(ra[0]), .req_wdata(rwd[0]), .req_done(dn[0]), .req_rdata(rd[0]),
        .mem_en(men[0]), .mem_we(mwe[0]), .mem_addr(maddr[0]), .mem_wdata(mwd[0]),
        .mem_rdata(mrd[0]));

    mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut_l2 (
        .clk(clk), .reset(rst_n[1]), .req_valid(rv[1]), .req_we(rwe[1]),
        .req_addr(ra[1]), .req_wdata(rwd[1]), .req_done(dn[1]), .req_rdata(rd[1]),
        .mem_en(men[1]), .mem_we(mwe[1]), .mem_addr(maddr[1]), .mem_wdata(mwd[1]),
        .mem_rdata(mrd[1]));

    mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut_l3 (
        .clk(clk), .reset(rst_n[2]), .req_valid(rv[2]), .req_we(rwe[2]),
        .req_addr(ra[2]), .req_wdata(rwd[2]), .req_done(dn[2]), .req_rdata(rd[2]),
        .mem_en(men[2]), .mem_we(mwe[2]), .mem_addr(maddr[2]), .mem_wdata(mwd[2]),
        .mem_rdata(mrd[2]));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data is only valid in the MEM_LAT-th strobe cycle.
    logic [31:0] mem    [3][64];
    bit   [63:0] wr_vld [3];
    int          en_cnt [3];

    function automatic logic [31:0] init_word(input logic [5:0] a);
        case (a)
            6'h10:   return 32'hDEADBEEF;
            6'h11:   return 32'hCAFEF00D;
            default: return {16'hA5A5, 10'd0, a};
        endcase
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (men[k]) begin
                en_cnt[k] <= en_cnt[k] + 1;
                if (mwe[k]) begin
                    mem[k][maddr[k][5:0]]    <= mwd[k];
                    wr_vld[k][maddr[k][5:0]] <= 1'b1;
                end
            end else begin
                en_cnt[k] <= 0;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            mrd[k] = 32'hBAD0BAD0;
            if (men[k] && en_cnt[k] == k) begin
                mrd[k] = wr_vld[k][maddr[k][5:0]] ? mem[k][maddr[k][5:0]] : init_word(maddr[k][5:0]);
            end
        end
    end

    typedef struct {
        int          inst;
        logic [1:0]  done;
        logic [31:0] rdata;
        int          at_cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          en_total  [3];
    logic        last_we   [3];
    logic [31:0] last_addr [3];
    logic [31:0] last_wd   [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input int k, input int who, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        rv[k][who]          = 1'b1;
        rwe[k][who]         = we;
        ra[k][who*32 +: 32]  = a;
        rwd[k][who*32 +: 32] = d;
    endtask

    task automatic expect_done(input int k, input logic [1:0] d, input logic [31:0] r, input int c);
        exp_t e;
        e.inst   = k;
        e.done   = d;
        e.rdata  = r;
        e.at_cyc = c;
        sb_q.push_back(e);
    endtask

    task automatic wait_done(input int k, input int budget);
        int b = 0;
        while (dn[k] == 2'b00 && b < budget) begin
            @(negedge clk);
            b++;
        end
        if (dn[k] == 2'b00) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_done_timeout inst%0d actual=none required=done within %0d cycles", k, budget);
        end
    endtask

    task automatic wait_drain(input int budget);
        int b = 0;
        while (sb_q.size() != 0 && b < budget) begin
            @(negedge clk);
            #1;
            b++;
        end
        chk("scoreboard_drained", sb_q.size(), 0);
    endtask

    task automatic check_reset_values(input int k);
        chk($sformatf("rst_done_%0d", k),  {30'd0, dn[k]}, 32'd0);
        chk($sformatf("rst_rdata_%0d", k), rd[k], 32'd0);
        chk($sformatf("rst_men_%0d", k),   {31'd0, men[k]}, 32'd0);
        chk($sformatf("rst_mwe_%0d", k),   {31'd0, mwe[k]}, 32'd0);
        chk($sformatf("rst_maddr_%0d", k), maddr[k], 32'd0);
        chk($sformatf("rst_mwdata_%0d", k), mwd[k], 32'd0);
    endtask

    initial begin
        int n;
        int snap;
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0;
            rv[k]    = 2'b00;
            rwe[k]   = 2'b00;
            ra[k]    = '0;
            rwd[k]   = '0;
        end

        fork
            forever begin
                @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    if (men[k]) begin
                        en_total[k]++;
                        last_we[k]   = mwe[k];
                        last_addr[k] = maddr[k];
                        last_wd[k]   = mwd[k];
                    end
                    if (dn[k] != 2'b00) begin
                        n_cmp++;
                        if (sb_q.size() == 0) begin
                            n_err++;
                            $display("FAIL unexpected_done inst%0d actual=%b cyc=%0d required=no done", k, dn[k], cyc);
                        end else begin
                            exp_t e;
                            e = sb_q.pop_front();
                            if (e.inst != k || e.done !== dn[k] || e.rdata !== rd[k] || e.at_cyc != cyc) begin
                                n_err++;
                                $display("FAIL done_check actual: inst%0d done=%b rdata=%h cyc=%0d required: inst%0d done=%b rdata=%h cyc=%0d",
                                         k, dn[k], rd[k], cyc, e.inst, e.done, e.rdata, e.at_cyc);
                            end
                        end
                    end
                end
            end
        join_none

        #1;
        for (int k = 0; k < 3; k++) check_reset_values(k);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        repeat (2) @(negedge clk);

        // Core read, MEM_LAT=1
        n = cyc; snap = en_total[0];
        drive(0, 0, 1'b0, 32'h10, 32'h0);
        expect_done(0, 2'b01, 32'hDEADBEEF, n + 2);
        wait_done(0, 20);
        rv[0] = 2'b00;
        @(negedge clk); #1;
        chk("rd_len_l1", en_total[0] - snap, 1);
        chk("rd_addr_l1", last_addr[0], 32'h10);
        chk("rd_we_l1", {31'd0, last_we[0]}, 32'd0);
        repeat (2) @(negedge clk);

        // Loader write, MEM_LAT=1: read data register must keep its value
        n = cyc; snap = en_total[0];
        drive(0, 1, 1'b1, 32'h20, 32'h12345678);
        expect_done(0, 2'b10, 32'hDEADBEEF, n + 2);
        wait_done(0, 20);
        rv[0] = 2'b00;
        @(negedge clk); #1;
        chk("wr_len_l1", en_total[0] - snap, 1);
        chk("wr_addr_l1", last_addr[0], 32'h20);
        chk("wr_we_l1", {31'd0, last_we[0]}, 32'd1);
        chk("wr_wdata_l1", last_wd[0], 32'h12345678);
        repeat (2) @(negedge clk);

        // Both requesters held valid for four accesses
        n = cyc;
        drive(0, 0, 1'b0, 32'h10, 32'h0);
        drive(0, 1, 1'b0, 32'h11, 32'h0);
`ifdef ARB_ROUND_ROBIN_EN
        expect_done(0, 2'b01, 32'hDEADBEEF, n + 2);
        expect_done(0, 2'b10, 32'hCAFEF00D, n + 5);
        expect_done(0, 2'b01, 32'hDEADBEEF, n + 8);
        expect_done(0, 2'b10, 32'hCAFEF00D, n + 11);
`else
        expect_done(0, 2'b01, 32'hDEADBEEF, n + 2);
        expect_done(0, 2'b01, 32'hDEADBEEF, n + 5);
        expect_done(0, 2'b01, 32'hDEADBEEF, n + 8);
        expect_done(0, 2'b01, 32'hDEADBEEF, n + 11);
`endif
        repeat (11) @(negedge clk);
        rv[0] = 2'b00;
        wait_drain(10);
        repeat (3) @(negedge clk);

        // Core reads back the loader's write
        n = cyc;
        drive(0, 0, 1'b0, 32'h20, 32'h0);
        expect_done(0, 2'b01, 32'h12345678, n + 2);
        wait_done(0, 20);
        rv[0] = 2'b00;
        repeat (3) @(negedge clk);

        // MEM_LAT=3 read
        n = cyc; snap = en_total[2];
        drive(2, 0, 1'b0, 32'h10, 32'h0);
        expect_done(2, 2'b01, 32'hDEADBEEF, n + 4);
        wait_done(2, 20);
        rv[2] = 2'b00;
        @(negedge clk); #1;
        chk("rd_len_l3", en_total[2] - snap, 3);
        repeat (2) @(negedge clk);

        // Reset mid-access on the MEM_LAT=3 instance
        drive(2, 0, 1'b0, 32'h11, 32'h0);
        @(negedge clk); #2;
        chk("abort_men_before", {31'd0, men[2]}, 32'd1);
        rst_n[2] = 1'b0;
        #1;
        check_reset_values(2);
        rv[2] = 2'b00;
        repeat (3) @(negedge clk);
        n = cyc;
        rst_n[2] = 1'b1;
        drive(2, 0, 1'b0, 32'h11, 32'h0);
        expect_done(2, 2'b01, 32'hCAFEF00D, n + 4);
        wait_done(2, 20);
        rv[2] = 2'b00;
        repeat (3) @(negedge clk);

        // MEM_LAT=2: valid dropped after the first ACCESS cycle
        n = cyc; snap = en_total[1];
        drive(1, 0, 1'b0, 32'h10, 32'h0);
        expect_done(1, 2'b01, 32'hDEADBEEF, n + 3);
        @(negedge clk); #1;
        chk("drop_men_l2", {31'd0, men[1]}, 32'd1);
        rv[1] = 2'b00;
        repeat (8) @(negedge clk);
        #1;
        chk("drop_len_l2", en_total[1] - snap, 2);

        wait_drain(20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
